// File: rtl/payload_byte_feeder_pkg.sv
// payload_byte_feeder_pkg: shared constants, FSM encoding and case-fold helper for the payload feeder
package payload_byte_feeder_pkg;
  localparam int WIN_BYTES = 20;
  localparam int CHAR_W = 8;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;
  typedef enum logic [1:0] {IDLE, SERIAL, FLUSH, CLEAR} state_t;
  function automatic logic [CHAR_W-1:0] fold_case(input logic [CHAR_W-1:0] b);
    return (b >= ASCII_UPPER_A && b <= ASCII_UPPER_Z) ? b + CASE_OFFSET : b;
  endfunction
endpackage

// File: rtl/payload_byte_feeder_lane_picker.sv
// payload_lane_picker: picks the lowest set keep lane, its one-hot clear mask and whether it is the last one
module payload_lane_picker #(
  parameter int LANES = 8,
  localparam int LW = $clog2(LANES)
) (
  input  logic [LANES-1:0] i_keep,
  output logic [LW-1:0]    o_lane,
  output logic [LANES-1:0] o_clr,
  output logic             o_final
);
  // scan from the top so the lowest set lane wins
  always_comb begin
    o_lane = '0;
    o_clr = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (i_keep[k]) begin
        o_lane = LW'(k);
        o_clr = '0;
        o_clr[k] = 1'b1;
      end
    end
    o_final = (i_keep & ~o_clr) == '0;
  end
endmodule

// File: rtl/payload_byte_feeder.sv
// payload_byte_feeder: serialises AXI4-Stream beats into a byte-wide sliding window; FEEDER_FLUSH_EN adds a zero-byte drain after each packet
module payload_byte_feeder #(
  parameter int DATA_W = 64,
  parameter int WIN_BYTES = 20,
  parameter int OFS_W = 16
`ifdef FEEDER_FLUSH_EN
  , parameter int FLUSH_LEN = 20
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      s_tdata,
  input  logic [DATA_W/8-1:0]    s_tkeep,
  input  logic                   s_tlast,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [8*WIN_BYTES-1:0] fifo_in,
  output logic [8*WIN_BYTES-1:0] fifo_in_nocase,
  output logic [7:0]             char_out,
  output logic                   char_valid,
  output logic                   sop,
  output logic                   eop,
  output logic [OFS_W-1:0]       byte_offset
);
  import payload_byte_feeder_pkg::*;
  localparam int LANES = DATA_W / CHAR_W;
  localparam int LW = $clog2(LANES);
  localparam int WIN_W = CHAR_W * WIN_BYTES;
  state_t r_state, w_next, w_after, w_end;
  logic [DATA_W-1:0] r_data;
  logic [LANES-1:0] r_keep, w_clr;
  logic r_last, r_first;
  logic [LW-1:0] w_lane;
  logic w_final, w_emit, w_flush, w_clear, w_accept;
  logic [CHAR_W-1:0] w_byte;
`ifdef FEEDER_FLUSH_EN
  localparam int CW = $clog2(FLUSH_LEN + 1);
  logic [CW-1:0] r_cnt;
  logic w_flush_done;
  assign w_end = FLUSH;
  assign w_flush_done = r_cnt == CW'(FLUSH_LEN - 1);
  // counts drain bytes while in FLUSH
  always_ff @(posedge clk) r_cnt <= (rst || !w_flush) ? '0 : r_cnt + CW'(1);
`else
  assign w_end = CLEAR;
`endif
  payload_lane_picker #(.LANES(LANES)) u_pick (
    .i_keep (r_keep),
    .o_lane (w_lane),
    .o_clr  (w_clr),
    .o_final(w_final)
  );
  assign w_byte = r_data[CHAR_W*int'(w_lane) +: CHAR_W];
  assign w_accept = s_tvalid && s_tready;
  assign w_after = |s_tkeep ? SERIAL : s_tlast ? w_end : IDLE;
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // next state and per-cycle controls; a new beat is only taken while the held one is fully consumed
  always_comb begin
    w_next = r_state;
    s_tready = 1'b0;
    w_emit = 1'b0;
    w_flush = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      IDLE: begin
        s_tready = 1'b1;
        w_next = s_tvalid ? w_after : IDLE;
      end
      SERIAL: begin
        w_emit = 1'b1;
        s_tready = w_final && !r_last;
        w_next = !w_final ? SERIAL : r_last ? w_end : s_tvalid ? w_after : IDLE;
      end
`ifdef FEEDER_FLUSH_EN
      FLUSH: begin
        w_flush = 1'b1;
        w_next = w_flush_done ? CLEAR : FLUSH;
      end
`endif
      CLEAR: begin
        w_clear = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // beat holding register, window shifting and per-byte sideband
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
      r_first <= 1'b1;
      fifo_in <= '0;
      fifo_in_nocase <= '0;
      char_out <= '0;
      char_valid <= 1'b0;
      sop <= 1'b0;
      eop <= 1'b0;
      byte_offset <= '0;
    end else begin
      if (w_accept) begin
        r_data <= s_tdata;
        r_keep <= s_tkeep;
        r_last <= s_tlast;
      end else if (w_emit) r_keep <= r_keep & ~w_clr;
      char_valid <= w_emit || w_flush;
      sop <= w_emit && r_first;
      eop <= w_emit && w_final && r_last;
      if (w_emit) begin
        fifo_in <= {fifo_in[WIN_W-CHAR_W-1:0], w_byte};
        fifo_in_nocase <= {fifo_in_nocase[WIN_W-CHAR_W-1:0], fold_case(w_byte)};
        char_out <= w_byte;
        byte_offset <= r_first ? '0 : (&byte_offset ? byte_offset : byte_offset + OFS_W'(1));
        r_first <= 1'b0;
      end else if (w_flush) begin
        fifo_in <= {fifo_in[WIN_W-CHAR_W-1:0], {CHAR_W{1'b0}}};
        fifo_in_nocase <= {fifo_in_nocase[WIN_W-CHAR_W-1:0], {CHAR_W{1'b0}}};
        char_out <= '0;
      end else if (w_clear) begin
        fifo_in <= '0;
        fifo_in_nocase <= '0;
        byte_offset <= '0;
        r_first <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_payload_byte_feeder.sv
// tb_payload_byte_feeder: table-driven beats with a byte scoreboard plus timing and reset sequences
module tb_payload_byte_feeder;
`ifdef FEEDER_FLUSH_EN
  localparam int F = 20;
`else
  localparam int F = 0;
`endif
  logic clk, rst;
  logic [63:0] s_tdata;
  logic [7:0] s_tkeep;
  logic s_tlast, s_tvalid, s_tready;
  logic [159:0] fifo_in, fifo_in_nocase;
  logic [7:0] char_out;
  logic char_valid, sop, eop;
  logic [15:0] byte_offset;
  payload_byte_feeder dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .fifo_in(fifo_in), .fifo_in_nocase(fifo_in_nocase),
    .char_out(char_out), .char_valid(char_valid), .sop(sop), .eop(eop), .byte_offset(byte_offset)
  );
  typedef struct {logic [7:0] ch; logic so; logic eo; logic [15:0] of; logic fl;} exp_t;
  typedef struct {logic [63:0] d; logic [7:0] k; logic l; int n; int p;} vec_t;
  exp_t sb[$];
  exp_t mx;
  vec_t tbl[8];
  int n_chk = 0, n_pass = 0, n_payload = 0, run = 0, max_run = 0, pulses = 0;
  logic m_first;
  logic [15:0] m_ofs;
  logic [63:0] snap_raw, snap_nc;
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  function automatic logic [7:0] lc(input logic [7:0] b);
    return (b inside {[8'h41:8'h5A]}) ? (b | 8'h20) : b;
  endfunction
  function automatic logic [63:0] lanes(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = s[8*(7-i) +: 8];
    return r;
  endfunction
  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    exp_t e;
    int t;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) begin
        e.ch = d[8*i +: 8];
        e.so = m_first;
        e.eo = l && ((k >> (i + 1)) == 8'h00);
        e.of = m_first ? 16'd0 : (m_ofs == 16'hFFFF ? m_ofs : m_ofs + 16'd1);
        e.fl = 1'b0;
        m_first = 1'b0;
        m_ofs = e.of;
        sb.push_back(e);
      end
    end
    if (l) begin
      for (int i = 0; i < F; i++) sb.push_back('{ch: 8'h00, so: 1'b0, eo: 1'b0, of: m_ofs, fl: 1'b1});
      m_first = 1'b1;
      m_ofs = 16'd0;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_tready && t < 400);
    if (!s_tready) chk("send tready timeout", s_tready, 1);
    @(posedge clk);
    #1 s_tvalid = 1'b0;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain queue empty", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  // scoreboard: every valid byte must match the next expected entry
  always @(negedge clk) begin
    if (!rst) begin
      run = char_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (s_tready && char_valid) pulses++;
      if (char_valid) begin
        if (sb.size() == 0) chk("spurious char_valid", char_valid, 0);
        else begin
          mx = sb.pop_front();
          chk("char_out", char_out, mx.ch);
          chk("sop", sop, mx.so);
          chk("eop", eop, mx.eo);
          chk("byte_offset", byte_offset, mx.of);
          chk("fifo_in newest", fifo_in[7:0], mx.ch);
          chk("nocase newest", fifo_in_nocase[7:0], lc(mx.ch));
          if (!mx.fl) n_payload++;
          if (eop) begin
            snap_raw = fifo_in[63:0];
            snap_nc = fifo_in_nocase[63:0];
          end
        end
      end
    end
  end
  initial begin
    int base, pkt_n;
    tbl[0] = '{lanes("HELLO WO"), 8'hFF, 1'b1, 8, 0};
    tbl[1] = '{lanes("ABCDEFGH"), 8'hFF, 1'b0, 8, 0};
    tbl[2] = '{lanes("ijklmnop"), 8'hFF, 1'b1, 8, 1};
    tbl[3] = '{lanes("01234567"), 8'hA5, 1'b1, 4, 0};
    tbl[4] = '{lanes("QRSTUVWX"), 8'hFF, 1'b0, 8, 0};
    tbl[5] = '{lanes("zzzzzzzz"), 8'h00, 1'b1, 0, 1};
    tbl[6] = '{lanes("--------"), 8'h00, 1'b0, 0, 0};
    tbl[7] = '{lanes("@AZ[az{~"), 8'hFF, 1'b1, 8, 0};
    rst = 1; s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tlast = 0;
    m_first = 1; m_ofs = 0; snap_raw = '0; snap_nc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset fifo_in", fifo_in, 0);
    chk("reset nocase", fifo_in_nocase, 0);
    chk("reset char_out", char_out, 0);
    chk("reset char_valid", char_valid, 0);
    chk("reset sop", sop, 0);
    chk("reset eop", eop, 0);
    chk("reset byte_offset", byte_offset, 0);
    chk("reset s_tready", s_tready, 1);
    base = n_payload; pkt_n = 0; max_run = 0; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].d, tbl[i].k, tbl[i].l);
      pkt_n += tbl[i].n;
      if (tbl[i].l) begin
        drain();
        chk($sformatf("vec%0d payload bytes", i), n_payload - base, pkt_n);
        chk($sformatf("vec%0d contiguous run", i), max_run, pkt_n + F);
        chk($sformatf("vec%0d tready pulses", i), pulses, tbl[i].p);
        chk($sformatf("vec%0d window cleared", i), fifo_in, 0);
        chk($sformatf("vec%0d nocase cleared", i), fifo_in_nocase, 0);
        chk($sformatf("vec%0d tready idle", i), s_tready, 1);
        if (i == 0) begin
          chk("HELLO raw window", snap_raw, "HELLO WO");
          chk("HELLO nocase window", snap_nc, "hello wo");
        end
        @(posedge clk);
        #1 base = n_payload; pkt_n = 0; max_run = 0; pulses = 0; snap_raw = '0; snap_nc = '0;
      end
    end
    send(64'h4241, 8'h03, 1'b1);
    for (int c = 1; c <= 4 + F; c++) begin
      @(negedge clk);
      chk($sformatf("AB tready c%0d", c), s_tready, c == 4 + F);
      if (c == 1) chk("AB char_valid c1", char_valid, 0);
      if (c == 2) chk("AB char_valid c2", char_valid, 1);
      if (c == 3) chk("AB char c3", char_out, F == 0 ? 8'h42 : 8'h42);
      if (c == 4 + F) chk("AB window cleared", fifo_in, 0);
    end
    drain();
    @(posedge clk);
    #1 send(lanes("QRSTUVWX"), 8'hFF, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    chk("midrst fifo_in", fifo_in, 0);
    chk("midrst nocase", fifo_in_nocase, 0);
    chk("midrst char_out", char_out, 0);
    chk("midrst char_valid", char_valid, 0);
    chk("midrst sop", sop, 0);
    chk("midrst eop", eop, 0);
    chk("midrst byte_offset", byte_offset, 0);
    chk("midrst s_tready", s_tready, 1);
    sb.delete();
    m_first = 1; m_ofs = 0;
    rst = 0;
    @(posedge clk);
    #1 base = n_payload;
    send(64'h7978, 8'h03, 1'b1);
    drain();
    chk("post-reset payload bytes", n_payload - base, 2);
    chk("post-reset window cleared", fifo_in, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
